// File: rtl/game_pkg.sv
// Shared game state encoding and score helpers for the
// controller, timer and display stages.
package game_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_MENU  = 3'b000,
    S_GAME  = 3'b001,
    S_P1WIN = 3'b010,
    S_P2WIN = 3'b011,
    S_TIE   = 3'b100,
    S_POINT = 3'b101,
    S_PAUSE = 3'b110
  } game_state_e;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] s,
    input logic       en
  );
    return (en && s != 4'hf) ? s + 4'd1 : s;
  endfunction

  function automatic game_state_e judge(
    input logic [3:0] a,
    input logic [3:0] b
  );
    if (a > b) return S_P1WIN;
    if (b > a) return S_P2WIN;
    return S_TIE;
  endfunction

endpackage

// File: rtl/game_ctrl_edge_detect.sv
// Rising-edge one-pulse detector for button levels.
// A level held high through reset must fall before it can fire.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic prev;
  logic armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= level;
      armed <= armed | ~level;
    end
  end

  assign pulse = level & ~prev & armed;

endmodule

// File: rtl/game_ctrl.sv
// Match controller FSM: scoring, point hold, win/tie resolution.
// Optional pause support when GAME_CTRL_PAUSE_EN is defined.
module game_ctrl
  import game_pkg::*;
#(
  parameter int WIN_SCORE  = 5,
  parameter int POINT_HOLD = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic               p1_goal,
  input  logic               p2_goal,
  input  logic               time_up,
  output logic [STATE_W-1:0] state,
  output logic [3:0]         p1_score,
  output logic [3:0]         p2_score,
  output logic [1:0]         point_who
);

  localparam logic [3:0] WIN  = 4'(WIN_SCORE);
  localparam logic [7:0] HOLD = 8'(POINT_HOLD - 1);

  game_state_e state_q, state_d;
  logic [3:0]  p1_q, p1_d, p2_q, p2_d;
  logic [3:0]  p1_i, p2_i;
  logic [1:0]  who_q, who_d;
  logic [7:0]  hold_q, hold_d;
  logic        w1, w2;
  logic        start_p;

  edge_detect u_start (
    .clk   (clk),
    .rst_n (rst_n),
    .level (start),
    .pulse (start_p)
  );

`ifdef GAME_CTRL_PAUSE_EN
  logic pause_p;

  edge_detect u_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .level (pause),
    .pulse (pause_p)
  );
`else
  wire unused_pause = pause;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_MENU;
      p1_q    <= 4'd0;
      p2_q    <= 4'd0;
      who_q   <= 2'b00;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      who_q   <= who_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    who_d   = who_q;
    hold_d  = hold_q;
    p1_i    = sat_inc(p1_q, p1_goal);
    p2_i    = sat_inc(p2_q, p2_goal);
    w1      = p1_i >= WIN;
    w2      = p2_i >= WIN;
    unique case (state_q)
      S_MENU: begin
        if (start_p) begin
          state_d = S_GAME;
          p1_d    = 4'd0;
          p2_d    = 4'd0;
          who_d   = 2'b00;
        end
      end
      S_GAME: begin
        // goal is counted before any time-up resolution
        if (p1_goal || p2_goal) begin
          p1_d  = p1_i;
          p2_d  = p2_i;
          who_d = {p2_goal, p1_goal};
          if (w1 && w2)   state_d = S_TIE;
          else if (w1)    state_d = S_P1WIN;
          else if (w2)    state_d = S_P2WIN;
          else if (time_up)
            state_d = judge(p1_i, p2_i);
          else begin
            state_d = S_POINT;
            hold_d  = HOLD;
          end
        end else if (time_up) begin
          state_d = judge(p1_q, p2_q);
        end
`ifdef GAME_CTRL_PAUSE_EN
        else if (pause_p) begin
          state_d = S_PAUSE;
        end
`endif
      end
      S_POINT: begin
        if (hold_q == 8'd0) state_d = S_GAME;
        else                hold_d  = hold_q - 8'd1;
      end
      S_P1WIN, S_P2WIN, S_TIE: begin
        if (start_p) state_d = S_MENU;
      end
`ifdef GAME_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (start_p)      state_d = S_MENU;
        else if (pause_p) state_d = S_GAME;
      end
`endif
      default: state_d = S_MENU;
    endcase
  end

  assign state     = state_q;
  assign p1_score  = p1_q;
  assign p2_score  = p2_q;
  assign point_who = who_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed vector bench for game_ctrl (WIN_SCORE=5, POINT_HOLD=3).
module tb_game_ctrl;

  localparam logic [2:0] M   = 3'b000;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] W1  = 3'b010;
  localparam logic [2:0] W2  = 3'b011;
  localparam logic [2:0] T   = 3'b100;
  localparam logic [2:0] PT  = 3'b101;
  localparam logic [2:0] PS  = 3'b110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, pause, p1_goal, p2_goal, time_up;
  logic [2:0] state;
  logic [3:0] p1_score, p2_score;
  logic [1:0] point_who;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       st, ps, g1, g2, tu;
    logic [2:0] es;
    logic [3:0] e1, e2;
    logic [1:0] ew;
  } vec_t;

  vec_t tbl[$];

  game_ctrl #(.WIN_SCORE(5), .POINT_HOLD(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .p1_goal   (p1_goal),
    .p2_goal   (p2_goal),
    .time_up   (time_up),
    .state     (state),
    .p1_score  (p1_score),
    .p2_score  (p2_score),
    .point_who (point_who)
  );

  always #5 clk = ~clk;

  task automatic add(
    input logic st, ps, g1, g2, tu,
    input logic [2:0] es,
    input logic [3:0] e1, e2,
    input logic [1:0] ew
  );
    vec_t v;
    v.st = st; v.ps = ps; v.g1 = g1; v.g2 = g2; v.tu = tu;
    v.es = es; v.e1 = e1; v.e2 = e2; v.ew = ew;
    tbl.push_back(v);
  endtask

  // goal, then noise in POINT, then return to GAME
  task automatic add_goal(
    input logic g1, g2,
    input logic [3:0] e1, e2
  );
    add(0, 0, g1, g2, 0, PT, e1, e2, {g2, g1});
    add(0, 0, 1, 1, 1, PT, e1, e2, {g2, g1});
    add(0, 0, 0, 0, 0, PT, e1, e2, {g2, g1});
    add(0, 0, 0, 0, 0, G,  e1, e2, {g2, g1});
  endtask

  task automatic add_back(
    input logic [3:0] e1, e2,
    input logic [1:0] ew
  );
    add(1, 0, 0, 0, 0, M, e1, e2, ew);
    add(0, 0, 0, 0, 0, M, e1, e2, ew);
    add(1, 0, 0, 0, 0, G, 0, 0, 2'b00);
    add(0, 0, 0, 0, 0, G, 0, 0, 2'b00);
  endtask

  task automatic chk(
    input string      nm,
    input logic [2:0] es,
    input logic [3:0] e1, e2,
    input logic [1:0] ew
  );
    tests++;
    if ({state, p1_score, p2_score, point_who} !== {es, e1, e2, ew}) begin
      fails++;
      $display("FAIL %s: got st=%b p1=%0d p2=%0d who=%b, want st=%b p1=%0d p2=%0d who=%b",
               nm, state, p1_score, p2_score, point_who, es, e1, e2, ew);
    end
  endtask

  task automatic cyc(input logic st, ps, g1, g2, tu);
    @(negedge clk);
    start = st; pause = ps; p1_goal = g1; p2_goal = g2; time_up = tu;
    @(posedge clk);
    #1;
  endtask

  initial begin
    add(0, 0, 0, 0, 0, M, 0, 0, 2'b00);
    add(1, 0, 0, 0, 0, G, 0, 0, 2'b00);
    for (int i = 0; i < 9; i++) add(1, 0, 0, 0, 0, G, 0, 0, 2'b00);
    add(0, 0, 0, 0, 0, G, 0, 0, 2'b00);
    add_goal(1, 0, 1, 0);
    add_goal(1, 0, 2, 0);
    add_goal(1, 0, 3, 0);
    add_goal(1, 0, 4, 0);
    add_goal(0, 1, 4, 1);
    add_goal(0, 1, 4, 2);
    add(0, 0, 1, 0, 0, W1, 5, 2, 2'b01);
    add(0, 0, 0, 1, 1, W1, 5, 2, 2'b01);
    add_back(5, 2, 2'b01);
    for (int i = 1; i <= 3; i++) add_goal(1, 0, 4'(i), 0);
    for (int i = 1; i <= 3; i++) add_goal(0, 1, 3, 4'(i));
    add(0, 0, 0, 0, 1, T, 3, 3, 2'b10);
    add_back(3, 3, 2'b10);
    for (int i = 1; i <= 3; i++) add_goal(1, 0, 4'(i), 0);
    for (int i = 1; i <= 3; i++) add_goal(0, 1, 3, 4'(i));
    add(0, 0, 0, 1, 1, W2, 3, 4, 2'b10);
    add_back(3, 4, 2'b10);
    add_goal(0, 1, 0, 1);
    add(0, 0, 0, 0, 1, W2, 0, 1, 2'b10);
    add_back(0, 1, 2'b10);
    for (int i = 1; i <= 4; i++) add_goal(1, 0, 4'(i), 0);
    for (int i = 1; i <= 4; i++) add_goal(0, 1, 4, 4'(i));
    add(0, 0, 1, 1, 0, T, 5, 5, 2'b11);

    rst_n = 1'b0;
    start = 0; pause = 0; p1_goal = 0; p2_goal = 0; time_up = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", M, 0, 0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].st, tbl[i].ps, tbl[i].g1, tbl[i].g2, tbl[i].tu);
      chk($sformatf("vec%0d", i), tbl[i].es, tbl[i].e1, tbl[i].e2, tbl[i].ew);
    end

    cyc(1, 0, 0, 0, 0); chk("tie_to_menu", M, 5, 5, 2'b11);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0); chk("new_game", G, 0, 0, 2'b00);
    cyc(0, 0, 1, 0, 0); chk("goal_point", PT, 1, 0, 2'b01);

    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk("reset_mid_point", M, 0, 0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk($sformatf("held_start%0d", i), M, 0, 0, 2'b00);
    end
    cyc(0, 0, 0, 0, 0); chk("start_fall", M, 0, 0, 2'b00);
    cyc(1, 0, 0, 0, 0); chk("start_rearm", G, 0, 0, 2'b00);
    cyc(0, 0, 1, 0, 0); chk("point_again", PT, 1, 0, 2'b01);
    cyc(0, 0, 0, 0, 0); chk("hold2", PT, 1, 0, 2'b01);
    cyc(0, 0, 0, 0, 0); chk("hold1", PT, 1, 0, 2'b01);
    cyc(0, 0, 0, 0, 0); chk("hold_done", G, 1, 0, 2'b01);

`ifdef GAME_CTRL_PAUSE_EN
    cyc(0, 1, 0, 0, 0); chk("pause_enter", PS, 1, 0, 2'b01);
    cyc(0, 1, 1, 1, 1); chk("pause_ignore", PS, 1, 0, 2'b01);
    cyc(0, 0, 0, 1, 0); chk("pause_hold", PS, 1, 0, 2'b01);
    cyc(0, 1, 0, 0, 0); chk("pause_resume", G, 1, 0, 2'b01);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); chk("pause_again", PS, 1, 0, 2'b01);
    cyc(1, 0, 0, 0, 0); chk("pause_menu", M, 1, 0, 2'b01);
`else
    cyc(0, 1, 0, 0, 0); chk("pause_off1", G, 1, 0, 2'b01);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); chk("pause_off2", G, 1, 0, 2'b01);
    cyc(0, 0, 0, 0, 1); chk("timeup_p1", W1, 1, 0, 2'b01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5, the score (1..15) that ends the match immediately.
REQ-002 SHALL have parameter POINT_HOLD, default 3, the cycles (1..255) spent in POINT after a goal.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  start/confirm button level (synchronous, debounced upstream).
REQ-006 SHALL have port pause  input  1  pause button level (used only with GAME_CTRL_PAUSE_EN).
REQ-007 SHALL have port p1_goal  input  1  one-cycle goal pulse, player 1.
REQ-008 SHALL have port p2_goal  input  1  one-cycle goal pulse, player 2.
REQ-009 SHALL have port time_up  input  1  high while the round timer reads zero.
REQ-010 SHALL have port state  output  3  registered game state driving the timer and display stages.
REQ-011 SHALL have port p1_score  output  4  registered player 1 score.
REQ-012 SHALL have port p2_score  output  4  registered player 2 score.
REQ-013 SHALL have port point_who  output  2  registered scorer of the last goal: bit0 is P1, bit1 is P2.

Function
REQ-014 SHALL encode states as MENU=000, GAME=001, P1WIN=010, P2WIN=011, TIE=100, POINT=101, PAUSE=110; 111 is never produced.
REQ-015 SHALL act only on start and pause rising edges (level high now, low in the previous cycle); a held level SHALL act once.
REQ-016 SHALL register all outputs; an input event sampled at edge n becomes visible after edge n, with one cycle of latency.
REQ-017 MENU: on a start edge, go to GAME and clear the scores and point_who to 0 in the same edge.
REQ-018 GAME: on any goal pulse, increment each scoring player's score, saturating at 15, and load point_who; both pulses in one cycle score both players (point_who=11).
REQ-019 GAME: after the increment, if exactly one score >= WIN_SCORE, go to that player's WIN state; if both are >= WIN_SCORE, go to TIE; otherwise go to POINT.
REQ-020 GAME: if time_up is high with no goal, go to P1WIN, P2WIN, or TIE by comparing the scores.
REQ-021 GAME: if a goal and time_up arrive in the same cycle, count the goal first, then apply REQ-019; if no one has won, resolve by REQ-020 using the updated scores.
REQ-022 POINT: load a hold counter with POINT_HOLD-1 on entry and return to GAME when it reaches 0; goals and time_up SHALL be ignored in POINT.
REQ-023 P1WIN/P2WIN/TIE: hold the scores; a start edge returns to MENU; all other inputs SHALL be ignored.
REQ-024 The internal hold counter SHALL be 8 bits wide and SHALL never wrap.

Reset
REQ-025 When rst_n is low, the block SHALL asynchronously set state=MENU, scores=0, point_who=0, hold counter=0, and both edge-detect history bits=0.
REQ-026 Reset asserted mid-POINT or mid-PAUSE SHALL abandon the match, with no residual hold count.
REQ-027 A start held high through reset release SHALL produce no edge until it falls and rises again; the history bit SHALL track the level from the first clock after release.

Configuration
REQ-028 With macro GAME_CTRL_PAUSE_EN defined, a pause edge in GAME SHALL go to PAUSE, and a pause edge in PAUSE SHALL return to GAME.
REQ-029 In PAUSE, goals and time_up SHALL be ignored and the scores held; a start edge in PAUSE SHALL go to MENU.
REQ-030 Without GAME_CTRL_PAUSE_EN, the pause input SHALL be ignored, PAUSE SHALL be unreachable, and no pause edge detector SHALL be built.

Structure
REQ-031 The state encodings and the state width SHALL live in shared package game_pkg, used also by the timer and display stages.
REQ-032 Rising-edge one-pulse detection SHALL be sub-module edge_detect, instanced once for start and once for pause when it is enabled.

Verification
REQ-033 Reset, then start edge -> GAME next cycle, scores 0/0; start held 10 cycles -> exactly one transition.
REQ-034 In GAME, p1_goal -> POINT with p1_score=1 and point_who=01; after 3 cycles -> GAME.
REQ-035 At scores 4/2, p1_goal -> P1WIN, p1_score=5; a later start edge -> MENU.
REQ-036 At scores 3/3, time_up -> TIE; at 3/3, p2_goal with time_up in the same cycle -> P2WIN at 3/4.
REQ-037 At 4/4, p1_goal and p2_goal in the same cycle -> TIE at 5/5 with point_who=11.
REQ-038 Reset pulsed mid-POINT -> MENU immediately and 0/0; with GAME_CTRL_PAUSE_EN, a pause edge -> 110, goals ignored, pause edge -> 001.
